// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR burst master.
// A core request (address, beats-1, direction) is turned into one AR/R or
// AW/W/B transaction. Read data and write data stream straight through the
// core ports; the FSM only supplies the handshakes and the beat framing.
// Optional: define AXI_BURST_MASTER_RESP_CHECK_EN to build a sticky err_o
// that flags bad RRESP/BRESP, foreign RID/BID and a misplaced RLAST.
module axi_burst_master #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16,
    parameter int MST_ID    = 0
) (
    input  logic                clk,
    input  logic                rst,
    // core request
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [3:0]          req_len_i,
    // core write data
    input  logic                wdat_valid_i,
    output logic                wdat_ready_o,
    input  logic [DATA_W-1:0]   wdat_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    // core response
    output logic                rdat_valid_o,
    output logic [DATA_W-1:0]   rdat_o,
    output logic                rdat_last_o,
    output logic                done_o,
    output logic                busy_o,
    output logic                err_o,
    // AXI AW
    output logic [ID_W-1:0]     awid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic [3:0]          awlen_o,
    output logic [2:0]          awsize_o,
    output logic [1:0]          awburst_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    // AXI W
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    // AXI B
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    // AXI AR
    output logic [ID_W-1:0]     arid_o,
    output logic [ADDR_W-1:0]   araddr_o,
    output logic [3:0]          arlen_o,
    output logic [2:0]          arsize_o,
    output logic [1:0]          arburst_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    // AXI R
    input  logic [ID_W-1:0]     rid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o
);

    localparam logic [2:0]      AX_SIZE  = 3'($clog2(DATA_W / 8));
    localparam logic [1:0]      AX_INCR  = 2'b01;
    localparam logic [3:0]      MAX_LEN  = 4'(MAX_BEATS - 1);
    localparam logic [ID_W-1:0] OWN_ID   = ID_W'(MST_ID);

    typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [3:0]        wbeat_q;
    logic              req_ready_q, busy_q, done_q;
    logic              arvalid_q, rready_q, awvalid_q, bready_q;

    logic              in_w;
    logic              req_fire, ar_fire, r_fire, aw_fire, w_fire, b_fire;

    // Requests longer than the configured maximum are cut down, not rejected.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    assign in_w     = (state == ST_W);
    assign req_fire = req_valid_i & req_ready_q;
    assign ar_fire  = arvalid_q & arready_i;
    assign r_fire   = rready_q & rvalid_i;
    assign aw_fire  = awvalid_q & awready_i;
    assign w_fire   = in_w & wdat_valid_i & wready_i;
    assign b_fire   = bready_q & bvalid_i;

    // Capture the transfer descriptor when a request is accepted.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            addr_q <= req_addr_i;
            len_q  <= clamp_len(req_len_i);
        end
    end

    // Transaction FSM; every handshake output is a register so no AXI ready
    // feeds back combinationally into a valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            wbeat_q     <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_write_i) begin
                            state     <= ST_AW;
                            awvalid_q <= 1'b1;
                        end else begin
                            state     <= ST_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (ar_fire) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= ST_R;
                    end
                end
                ST_R: begin
                    // The slave's RLAST ends the burst, whatever the beat count.
                    if (r_fire && rlast_i) begin
                        rready_q    <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        wbeat_q   <= 4'd0;
                        state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_fire) begin
                        if (wbeat_q == len_q) begin
                            wbeat_q  <= 4'd0;
                            bready_q <= 1'b1;
                            state    <= ST_B;
                        end else begin
                            wbeat_q <= wbeat_q + 4'd1;
                        end
                    end
                end
                ST_B: begin
                    if (b_fire) begin
                        bready_q    <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_BURST_MASTER_RESP_CHECK_EN
    logic [3:0] rbeat_q;
    logic       err_q;

    // Track the read beat index and latch any protocol/response error until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbeat_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            if (r_fire) begin
                rbeat_q <= rlast_i ? 4'd0 : rbeat_q + 4'd1;
                if ((rresp_i != 2'b00) || (rid_i != OWN_ID) ||
                    (rlast_i && (rbeat_q != len_q)))
                    err_q <= 1'b1;
            end
            if (b_fire && ((bresp_i != 2'b00) || (bid_i != OWN_ID)))
                err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{rid_i, rresp_i, bid_i, bresp_i};
    assign err_o       = 1'b0;
`endif

    assign req_ready_o  = req_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    assign awid_o       = OWN_ID;
    assign awaddr_o     = addr_q;
    assign awlen_o      = len_q;
    assign awsize_o     = AX_SIZE;
    assign awburst_o    = AX_INCR;
    assign awvalid_o    = awvalid_q;

    assign arid_o       = OWN_ID;
    assign araddr_o     = addr_q;
    assign arlen_o      = len_q;
    assign arsize_o     = AX_SIZE;
    assign arburst_o    = AX_INCR;
    assign arvalid_o    = arvalid_q;

    // Write data is a gated pass-through: the core sees AXI backpressure directly.
    assign wvalid_o     = in_w & wdat_valid_i;
    assign wdat_ready_o = in_w & wready_i;
    assign wdata_o      = wdat_i;
    assign wstrb_o      = wstrb_i;
    assign wlast_o      = in_w & (wbeat_q == len_q);
    assign bready_o     = bready_q;

    // Read data is forwarded to the core in the cycle it is accepted.
    assign rready_o     = rready_q;
    assign rdat_valid_o = r_fire;
    assign rdat_o       = rdata_i;
    assign rdat_last_o  = r_fire & rlast_i;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: the bench plays both the core and the AXI
// slave, and predicts every output from the behavioural rules of the block.
module tb_axi_burst_master;

    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 8;
    localparam int MST_ID    = 0;
    localparam int STRB_W    = DATA_W / 8;

    logic              clk, rst;
    logic              req_valid_i, req_ready_o, req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [3:0]        req_len_i;
    logic              wdat_valid_i, wdat_ready_o;
    logic [DATA_W-1:0] wdat_i;
    logic [STRB_W-1:0] wstrb_i;
    logic              rdat_valid_o, rdat_last_o, done_o, busy_o, err_o;
    logic [DATA_W-1:0] rdat_o;
    logic [ID_W-1:0]   awid_o, arid_o, bid_i, rid_i;
    logic [ADDR_W-1:0] awaddr_o, araddr_o;
    logic [3:0]        awlen_o, arlen_o;
    logic [2:0]        awsize_o, arsize_o;
    logic [1:0]        awburst_o, arburst_o, bresp_i, rresp_i;
    logic              awvalid_o, awready_i, arvalid_o, arready_i;
    logic [DATA_W-1:0] wdata_o, rdata_i;
    logic [STRB_W-1:0] wstrb_o;
    logic              wlast_o, wvalid_o, wready_i;
    logic              bvalid_i, bready_o, rlast_i, rvalid_i, rready_o;

    axi_burst_master #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_BEATS(MAX_BEATS), .MST_ID(MST_ID)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i), .wstrb_i(wstrb_i),
        .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .rdat_last_o(rdat_last_o),
        .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rule: burst length saturates at MAX_BEATS-1.
    function automatic logic [3:0] model_len(input logic [3:0] len);
        if (int'(len) > MAX_BEATS - 1) return 4'(MAX_BEATS - 1);
        return len;
    endfunction

    task automatic check_err();
`ifdef AXI_BURST_MASTER_RESP_CHECK_EN
        check_eq("err_sticky", err_o, exp_err);
`else
        check_eq("err_tied", err_o, 1'b0);
`endif
    endtask

    // Write address and write data must never be offered together.
    always @(negedge clk) begin
        if (rst) check_eq("aw_w_overlap", awvalid_o & wvalid_o, 1'b0);
    end

    task automatic issue_req(input bit wr, input logic [31:0] addr, input logic [3:0] len);
        int waits;
        waits = 0;
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_len_i = len;
        while (!req_ready_o && waits < 20) begin
            tick();
            waits++;
        end
        check_eq("req_accept_wait", waits, 0);
        tick();
        req_valid_i = 1'b0;
        check_eq("busy_after_req", busy_o, 1'b1);
        check_eq("req_ready_busy", req_ready_o, 1'b0);
        check_eq("done_after_req", done_o, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len,
                           input int ar_stall, input int bad_beat);
        logic [3:0]  el;
        logic [31:0] d;
        int          gap;
        el = model_len(len);
        issue_req(1'b0, addr, len);
        // A stray R beat before the address is accepted must not be taken.
        rvalid_i = 1'b1; rlast_i = 1'b0;
        for (int c = 0; c <= ar_stall; c++) begin
            #1;
            check_eq("arvalid", arvalid_o, 1'b1);
            check_eq("araddr", araddr_o, addr);
            check_eq("arlen", arlen_o, el);
            check_eq("arsize", arsize_o, 3'd2);
            check_eq("arburst", arburst_o, 2'd1);
            check_eq("arid", arid_o, 4'(MST_ID));
            check_eq("rready_in_ar", rready_o, 1'b0);
            check_eq("rdat_valid_in_ar", rdat_valid_o, 1'b0);
            check_eq("req_ready_in_ar", req_ready_o, 1'b0);
            if (c == ar_stall) arready_i = 1'b1;
            tick();
        end
        arready_i = 1'b0; rvalid_i = 1'b0;
        check_eq("arvalid_drop", arvalid_o, 1'b0);
        check_eq("rready_in_r", rready_o, 1'b1);
        for (int b = 0; b <= int'(el); b++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                // The core presents its next request early; it must wait.
                req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'hDEAD_0000; req_len_i = 4'd0;
                #1;
                check_eq("rdat_valid_gap", rdat_valid_o, 1'b0);
                check_eq("req_ready_in_r", req_ready_o, 1'b0);
                check_eq("rready_gap", rready_o, 1'b1);
                tick();
            end
            d = $urandom;
            rvalid_i = 1'b1; rdata_i = d; rlast_i = (b == int'(el));
            rresp_i = (b == bad_beat) ? 2'b10 : 2'b00; rid_i = 4'(MST_ID);
            #1;
            check_eq("rdat_valid", rdat_valid_o, 1'b1);
            check_eq("rdat", rdat_o, d);
            check_eq("rdat_last", rdat_last_o, (b == int'(el)));
            check_eq("done_in_r", done_o, 1'b0);
            tick();
            rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00;
        end
        req_valid_i = 1'b0;
        if (bad_beat >= 0 && bad_beat <= int'(el)) exp_err = 1'b1;
        check_eq("read_done", done_o, 1'b1);
        check_eq("read_busy_end", busy_o, 1'b0);
        check_eq("read_req_ready_end", req_ready_o, 1'b1);
        check_eq("rready_end", rready_o, 1'b0);
        check_err();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len,
                            input int aw_stall, input bit pattern, input bit bad);
        logic [3:0]        el;
        bit                wv, wr;
        logic [31:0]       wd;
        logic [STRB_W-1:0] ws;
        int                beats, cyc, gap;
        el = model_len(len);
        issue_req(1'b1, addr, len);
        // The core is already offering data; it must not leak onto W yet.
        wdat_valid_i = 1'b1; wready_i = 1'b1; wdat_i = $urandom;
        for (int c = 0; c <= aw_stall; c++) begin
            #1;
            check_eq("awvalid", awvalid_o, 1'b1);
            check_eq("awaddr", awaddr_o, addr);
            check_eq("awlen", awlen_o, el);
            check_eq("awsize", awsize_o, 3'd2);
            check_eq("awburst", awburst_o, 2'd1);
            check_eq("awid", awid_o, 4'(MST_ID));
            check_eq("wvalid_in_aw", wvalid_o, 1'b0);
            check_eq("wdat_ready_in_aw", wdat_ready_o, 1'b0);
            check_eq("arvalid_in_aw", arvalid_o, 1'b0);
            if (c == aw_stall) awready_i = 1'b1;
            tick();
        end
        awready_i = 1'b0;
        check_eq("awvalid_drop", awvalid_o, 1'b0);
        beats = 0; cyc = 0;
        while (beats <= int'(el) && cyc < 200) begin
            wv = pattern ? 1'b1 : ($urandom_range(0, 3) != 0);
            wr = pattern ? (cyc != 1) : ($urandom_range(0, 3) != 0);
            wd = $urandom; ws = STRB_W'($urandom_range(0, 15));
            wdat_valid_i = wv; wready_i = wr; wdat_i = wd; wstrb_i = ws;
            #1;
            check_eq("wvalid", wvalid_o, wv);
            check_eq("wdat_ready", wdat_ready_o, wr);
            check_eq("wdata", wdata_o, wd);
            check_eq("wstrb", wstrb_o, ws);
            check_eq("wlast", wlast_o, (beats == int'(el)));
            if (wv && wr) beats++;
            tick();
            cyc++;
        end
        check_eq("w_beats", beats, int'(el) + 1);
        if (pattern) check_eq("w_cycles", cyc, 3);
        wdat_valid_i = 1'b1; wready_i = 1'b0;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g <= gap; g++) begin
            #1;
            check_eq("wvalid_in_b", wvalid_o, 1'b0);
            check_eq("wlast_in_b", wlast_o, 1'b0);
            check_eq("bready", bready_o, 1'b1);
            check_eq("done_in_b", done_o, 1'b0);
            if (g == gap) begin
                bvalid_i = 1'b1; bresp_i = bad ? 2'b10 : 2'b00; bid_i = 4'(MST_ID);
            end
            tick();
        end
        bvalid_i = 1'b0; bresp_i = 2'b00; wdat_valid_i = 1'b0;
        if (bad) exp_err = 1'b1;
        check_eq("write_done", done_o, 1'b1);
        check_eq("write_busy_end", busy_o, 1'b0);
        check_eq("bready_end", bready_o, 1'b0);
        check_eq("write_req_ready_end", req_ready_o, 1'b1);
        check_err();
    endtask

    task automatic reset_mid_write();
        issue_req(1'b1, 32'h0000_2000, 4'd5);
        awready_i = 1'b1;
        tick();
        awready_i = 1'b0;
        wdat_valid_i = 1'b1; wready_i = 1'b1; wdat_i = $urandom;
        tick();
        #1;
        check_eq("wvalid_before_rst", wvalid_o, 1'b1);
        rst = 1'b0;
        #1;
        exp_err = 1'b0;
        check_eq("rst_wvalid", wvalid_o, 1'b0);
        check_eq("rst_wdat_ready", wdat_ready_o, 1'b0);
        check_eq("rst_wlast", wlast_o, 1'b0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_req_ready", req_ready_o, 1'b1);
        check_eq("rst_awvalid", awvalid_o, 1'b0);
        check_eq("rst_bready", bready_o, 1'b0);
        check_err();
        tick();
        wdat_valid_i = 1'b0; wready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_len_i = '0;
        wdat_valid_i = 1'b0; wdat_i = '0; wstrb_i = '0;
        awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
        bid_i = '0; bresp_i = '0; bvalid_i = 1'b0;
        rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 1'b0; rvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_req_ready", req_ready_o, 1'b1);
        check_eq("reset_busy", busy_o, 1'b0);
        check_eq("reset_done", done_o, 1'b0);
        check_eq("reset_arvalid", arvalid_o, 1'b0);
        check_eq("reset_awvalid", awvalid_o, 1'b0);
        check_eq("reset_wvalid", wvalid_o, 1'b0);
        check_eq("reset_wlast", wlast_o, 1'b0);
        check_eq("reset_rready", rready_o, 1'b0);
        check_eq("reset_bready", bready_o, 1'b0);
        check_eq("reset_rdat_valid", rdat_valid_o, 1'b0);
        check_eq("reset_err", err_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        do_read(32'h0000_0100, 4'd3, 0, -1);
        do_write(32'h0000_0200, 4'd1, 0, 1'b1, 1'b0);
        do_read(32'h0000_0300, 4'd15, 0, -1);
        do_read(32'h0000_0400, 4'd2, 5, -1);
        do_read(32'h0000_0500, 4'd2, 0, 1);
        do_write(32'h0000_0600, 4'd0, 1, 1'b0, 1'b0);
        reset_mid_write();
        do_write(32'h0000_0700, 4'd4, 0, 1'b0, 1'b0);
        do_read(32'h0000_0800, 4'd1, 1, -1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), 1'b0, ($urandom_range(0, 9) == 0));
            else
                do_read($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)),
                        int'($urandom_range(0, 3)),
                        ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
